// File: rtl/cd4029b_interval_arbiter.sv
// Round-robin arbiter lending one CD4029B counter to NUM_REQ requesters for timed intervals.
// Grant one edge after IDLE sees REQ; GNT lasts LEN+1 cycles; REQ drop aborts; 2-cycle gap between grants.
module cd4029b_interval_arbiter #(
  parameter int NUM_REQ   = 2,
  parameter int CNT_WIDTH = 4
) (
  input  logic                         CLOCK,
  input  logic                         RESET,
  input  logic [NUM_REQ-1:0]           REQ,
  input  logic [NUM_REQ*CNT_WIDTH-1:0] LEN,
  output logic [NUM_REQ-1:0]           GNT,
  output logic [NUM_REQ-1:0]           DONE,
  output logic [NUM_REQ-1:0]           ABORTED,
  output logic                         BUSY,
  output logic                         CNT_PRESET,
  input  logic [CNT_WIDTH-1:0]         CNT_Q
);

  localparam int IDX_W = $clog2(NUM_REQ);
  localparam logic [NUM_REQ-1:0] ONE = NUM_REQ'(1);

  typedef enum logic [1:0] {IDLE, RUN, FIN} state_t;

  state_t               state;
  logic [IDX_W-1:0]     rr_ptr;
  logic [IDX_W-1:0]     win;
  logic [CNT_WIDTH-1:0] tgt;
  logic [IDX_W-1:0]     pick;
  logic                 pick_vld;
  int                   idx;

  // Scan downward so the candidate closest to rr_ptr is the last one written.
  always_comb begin
    pick_vld = 1'b0;
    pick     = '0;
    idx      = 0;
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      idx = (int'(rr_ptr) + k) % NUM_REQ;
      if (REQ[idx]) begin
        pick_vld = 1'b1;
        pick     = IDX_W'(idx);
      end
    end
  end

  always_ff @(posedge CLOCK) begin
    if (RESET) begin
      state      <= IDLE;
      GNT        <= '0;
      DONE       <= '0;
      ABORTED    <= '0;
      BUSY       <= 1'b0;
      CNT_PRESET <= 1'b1;
      rr_ptr     <= '0;
      win        <= '0;
      tgt        <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (pick_vld) begin
            win        <= pick;
            tgt        <= LEN[pick*CNT_WIDTH +: CNT_WIDTH];
            GNT        <= ONE << pick;
            CNT_PRESET <= 1'b0;
            BUSY       <= 1'b1;
            state      <= RUN;
          end
        end
        RUN: begin
          // A dropped request wins over a match on the same edge.
          if (!REQ[win]) begin
            ABORTED    <= ONE << win;
            GNT        <= '0;
            CNT_PRESET <= 1'b1;
            state      <= FIN;
          end else if (CNT_Q == tgt) begin
            DONE       <= ONE << win;
            GNT        <= '0;
            CNT_PRESET <= 1'b1;
            state      <= FIN;
          end
        end
        FIN: begin
          DONE    <= '0;
          ABORTED <= '0;
          BUSY    <= 1'b0;
          rr_ptr  <= (win == IDX_W'(NUM_REQ - 1)) ? '0 : win + 1'b1;
          state   <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_cd4029b_interval_arbiter.sv
// Directed bench for cd4029b_interval_arbiter with a behavioural CD4029B (synchronous preset, count up).
module tb_cd4029b_interval_arbiter;

  logic       CLOCK = 1'b0;
  logic       RESET = 1'b1;
  logic [1:0] REQ   = 2'b00;
  logic [7:0] LEN   = 8'h00;
  logic [1:0] GNT, DONE, ABORTED;
  logic       BUSY, CNT_PRESET;
  logic [3:0] cnt   = 4'd0;

  int total = 0;
  int bad   = 0;
  int n;

  cd4029b_interval_arbiter #(.NUM_REQ(2), .CNT_WIDTH(4)) dut (
    .CLOCK(CLOCK), .RESET(RESET), .REQ(REQ), .LEN(LEN),
    .GNT(GNT), .DONE(DONE), .ABORTED(ABORTED),
    .BUSY(BUSY), .CNT_PRESET(CNT_PRESET), .CNT_Q(cnt)
  );

  always #5 CLOCK = ~CLOCK;

  always @(posedge CLOCK) begin
    if (CNT_PRESET) cnt <= 4'd0;
    else            cnt <= cnt + 4'd1;
  end

  task automatic tick();
    @(posedge CLOCK);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Counts remaining GNT-high cycles, bounded so a stuck grant cannot hang the run.
  task automatic count_gnt(output int cycles);
    cycles = 0;
    while (GNT != 2'b00 && cycles < 40) begin
      cycles++;
      tick();
    end
  endtask

  initial begin
    // 1. reset
    tick(); tick();
    chk("rst_gnt",    32'(GNT), 0);
    chk("rst_done",   32'(DONE), 0);
    chk("rst_abort",  32'(ABORTED), 0);
    chk("rst_busy",   32'(BUSY), 0);
    chk("rst_preset", 32'(CNT_PRESET), 1);
    chk("rst_cnt",    32'(cnt), 0);
    RESET = 1'b0;
    tick();
    chk("idle_gnt", 32'(GNT), 0);

    // 2. single request, LEN0=3
    REQ = 2'b01; LEN = 8'h03;
    tick();
    chk("s_busy",   32'(BUSY), 1);
    chk("s_preset", 32'(CNT_PRESET), 0);
    for (int i = 0; i < 4; i++) begin
      chk("s_gnt",  32'(GNT), 1);
      chk("s_cnt",  32'(cnt), 32'(i));
      chk("s_nodn", 32'(DONE), 0);
      tick();
    end
    chk("s_gnt_off", 32'(GNT), 0);
    chk("s_done",    32'(DONE), 1);
    chk("s_finbusy", 32'(BUSY), 1);
    chk("s_finpre",  32'(CNT_PRESET), 1);
    REQ = 2'b00;
    tick();
    chk("s_done_clr", 32'(DONE), 0);
    chk("s_idlebusy", 32'(BUSY), 0);
    chk("s_cnt0",     32'(cnt), 0);

    // 3. round-robin with both held; rr_ptr is 1 after requester 0 finished
    REQ = 2'b11; LEN = 8'h52;
    for (int g = 0; g < 4; g++) begin
      tick();
      chk("rr_gnt", 32'(GNT), (g % 2 == 0) ? 2 : 1);
      count_gnt(n);
      chk("rr_width", 32'(n), (g % 2 == 0) ? 6 : 3);
      chk("rr_done",  32'(DONE), (g % 2 == 0) ? 2 : 1);
      tick();
      chk("rr_gap_gnt",  32'(GNT), 0);
      chk("rr_gap_busy", 32'(BUSY), 0);
      chk("rr_gap_done", 32'(DONE), 0);
      if (g == 3) REQ = 2'b00;
    end

    // 4. boundaries: LEN0=0 then LEN0=15 (LEN change mid-run is ignored)
    REQ = 2'b01; LEN = 8'h00;
    tick();
    chk("b0_gnt", 32'(GNT), 1);
    tick();
    chk("b0_gnt_off", 32'(GNT), 0);
    chk("b0_done",    32'(DONE), 1);
    REQ = 2'b00;
    tick();
    REQ = 2'b01; LEN = 8'h0F;
    tick();
    for (int i = 0; i < 16; i++) begin
      chk("b15_gnt", 32'(GNT), 1);
      chk("b15_cnt", 32'(cnt), 32'(i));
      if (i == 5) LEN = 8'h02;
      tick();
    end
    chk("b15_gnt_off", 32'(GNT), 0);
    chk("b15_done",    32'(DONE), 1);
    REQ = 2'b00;
    tick();
    chk("b15_cnt0", 32'(cnt), 0);

    // 5. abort on cycle 2 of a LEN=10 grant
    REQ = 2'b01; LEN = 8'h0A;
    tick();
    chk("ab_gnt", 32'(GNT), 1);
    tick();
    chk("ab_cnt1", 32'(cnt), 1);
    REQ = 2'b00;
    tick();
    chk("ab_abort",  32'(ABORTED), 1);
    chk("ab_nodone", 32'(DONE), 0);
    chk("ab_gnt0",   32'(GNT), 0);
    chk("ab_preset", 32'(CNT_PRESET), 1);
    tick();
    chk("ab_clr",  32'(ABORTED), 0);
    chk("ab_cnt0", 32'(cnt), 0);
    chk("ab_busy", 32'(BUSY), 0);

    // 6. reset on cycle 3 of a LEN=8 grant; rr_ptr was 1 beforehand
    REQ = 2'b01; LEN = 8'h08;
    tick(); tick(); tick();
    chk("rm_cnt2", 32'(cnt), 2);
    RESET = 1'b1;
    tick();
    chk("rm_gnt",    32'(GNT), 0);
    chk("rm_preset", 32'(CNT_PRESET), 1);
    chk("rm_done",   32'(DONE), 0);
    chk("rm_abort",  32'(ABORTED), 0);
    chk("rm_busy",   32'(BUSY), 0);
    RESET = 1'b0; REQ = 2'b11; LEN = 8'h18;
    tick();
    chk("rm_ptr0", 32'(GNT), 1);
    count_gnt(n);
    chk("rm_width", 32'(n), 9);
    chk("rm_fin_done", 32'(DONE), 1);
    REQ = 2'b00;
    tick();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
